// File: rtl/UArch.sv
// Shared writeback micro-architecture constants, entry type and the register-file write qualifier.
package UArch;

  localparam int WB_MAX_PIPES    = 8;
  localparam int WB_ADDR_BITS    = 32;
  localparam int WB_DATA_BITS    = 32;
  localparam int WB_SEQ_NUM_BITS = 5;

  typedef struct packed {
    logic                       val;
    logic [WB_ADDR_BITS-1:0]    pc;
    logic [WB_SEQ_NUM_BITS-1:0] seq_num;
    logic [4:0]                 waddr;
    logic [WB_DATA_BITS-1:0]    wdata;
    logic                       wen;
  } wb_entry_t;

  // x0 is hardwired to zero, so a write to it is never architecturally visible.
  function automatic logic wb_rf_write(input logic val, input logic wen, input logic [4:0] waddr);
    return val & wen & (waddr != 5'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from a rotating pointer; the pointer moves past the
// winner only in cycles where en is high and a grant is issued.
module rr_arbiter
  import UArch::*;
#(
  parameter int p_width = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  input  logic               en,
  output logic [p_width-1:0] gnt
);

  localparam int PTR_W = $clog2(WB_MAX_PIPES);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;

  // Two passes give the wrap-around scan: pointer..top, then 0..pointer-1.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < p_width; i++) begin
      if (en && !found && req[i] && (i >= int'(ptr_q))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        ptr_d  = (i == p_width - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < p_width; i++) begin
      if (en && !found && req[i] && (i < int'(ptr_q))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        ptr_d  = (i == p_width - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin merge of execute pipes into one output register driving RF write + completion.
// Defining WRITEBACK_ARBITER_BYPASS_EN adds byp_val/byp_waddr/byp_wdata forwarding outputs.
module writeback_arbiter
  import UArch::*;
#(
  parameter int p_num_pipes    = 2,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                X_val,
  output logic [p_num_pipes-1:0]                X_rdy,
  input  logic [p_num_pipes*p_addr_bits-1:0]    X_pc,
  input  logic [p_num_pipes*p_seq_num_bits-1:0] X_seq_num,
  input  logic [p_num_pipes*5-1:0]              X_waddr,
  input  logic [p_num_pipes*p_data_bits-1:0]    X_wdata,
  input  logic [p_num_pipes-1:0]                X_wen,
  output logic                                  rf_wen,
  output logic [4:0]                            rf_waddr,
  output logic [p_data_bits-1:0]                rf_wdata,
`ifdef WRITEBACK_ARBITER_BYPASS_EN
  output logic                                  byp_val,
  output logic [4:0]                            byp_waddr,
  output logic [p_data_bits-1:0]                byp_wdata,
`endif
  output logic                                  C_val,
  input  logic                                  C_rdy,
  output logic [p_seq_num_bits-1:0]             C_seq_num,
  output logic [p_addr_bits-1:0]                C_pc
);

  logic                      s_val_q, s_val_d;
  logic [p_addr_bits-1:0]    s_pc_q, s_pc_d;
  logic [p_seq_num_bits-1:0] s_seq_q, s_seq_d;
  logic [4:0]                s_waddr_q, s_waddr_d;
  logic [p_data_bits-1:0]    s_wdata_q, s_wdata_d;
  logic                      s_wen_q, s_wen_d;

  logic                   can_accept;
  logic                   c_xfer;
  logic [p_num_pipes-1:0] gnt;

  // Reset gates the handshakes so nothing is granted or retired in the reset cycle.
  assign can_accept = ~rst & (~s_val_q | C_rdy);
  assign C_val      = s_val_q & ~rst;
  assign c_xfer     = C_val & C_rdy;

  rr_arbiter #(.p_width(p_num_pipes)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (X_val),
    .en  (can_accept),
    .gnt (gnt)
  );

  assign X_rdy = gnt;

  always_comb begin
    s_val_d   = s_val_q;
    s_pc_d    = s_pc_q;
    s_seq_d   = s_seq_q;
    s_waddr_d = s_waddr_q;
    s_wdata_d = s_wdata_q;
    s_wen_d   = s_wen_q;
    if (|gnt) begin
      s_val_d = 1'b1;
      for (int i = 0; i < p_num_pipes; i++) begin
        if (gnt[i]) begin
          s_pc_d    = X_pc[i*p_addr_bits +: p_addr_bits];
          s_seq_d   = X_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
          s_waddr_d = X_waddr[i*5 +: 5];
          s_wdata_d = X_wdata[i*p_data_bits +: p_data_bits];
          s_wen_d   = X_wen[i];
        end
      end
    end else if (c_xfer) begin
      s_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s_val_q <= 1'b0;
    else     s_val_q <= s_val_d;
  end

  // Payload is qualified by s_val_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s_pc_q    <= s_pc_d;
    s_seq_q   <= s_seq_d;
    s_waddr_q <= s_waddr_d;
    s_wdata_q <= s_wdata_d;
    s_wen_q   <= s_wen_d;
  end

  assign C_pc      = s_pc_q;
  assign C_seq_num = s_seq_q;
  assign rf_wen    = c_xfer & wb_rf_write(C_val, s_wen_q, s_waddr_q);
  assign rf_waddr  = s_waddr_q;
  assign rf_wdata  = s_wdata_q;

`ifdef WRITEBACK_ARBITER_BYPASS_EN
  // Forwarding view of the held result, independent of whether completion is accepted yet.
  assign byp_val   = wb_rf_write(C_val, s_wen_q, s_waddr_q);
  assign byp_waddr = s_waddr_q;
  assign byp_wdata = s_wdata_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a randomized run against a queue-level model.
module tb_writeback_arbiter;

  localparam int NP = 2;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int SB = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    X_val = '0;
  logic [NP-1:0]    X_rdy;
  logic [NP*AB-1:0] X_pc = '0;
  logic [NP*SB-1:0] X_seq_num = '0;
  logic [NP*5-1:0]  X_waddr = '0;
  logic [NP*DB-1:0] X_wdata = '0;
  logic [NP-1:0]    X_wen = '0;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [DB-1:0]    rf_wdata;
  logic             C_val;
  logic             C_rdy = 1'b0;
  logic [SB-1:0]    C_seq_num;
  logic [AB-1:0]    C_pc;
`ifdef WRITEBACK_ARBITER_BYPASS_EN
  logic             byp_val;
  logic [4:0]       byp_waddr;
  logic [DB-1:0]    byp_wdata;
`endif

  int vectors    = 0;
  int miscompares = 0;

  writeback_arbiter #(
    .p_num_pipes(NP), .p_addr_bits(AB), .p_data_bits(DB), .p_seq_num_bits(SB)
  ) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WRITEBACK_ARBITER_BYPASS_EN
    .byp_val(byp_val), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
`endif
    .C_val(C_val), .C_rdy(C_rdy), .C_seq_num(C_seq_num), .C_pc(C_pc)
  );

  always #5 clk = ~clk;

  task automatic set_pipe(input int i, input logic v, input logic [AB-1:0] pc, input logic [SB-1:0] seq,
                          input logic [4:0] wa, input logic [DB-1:0] wd, input logic we);
    X_val[i]             = v;
    X_pc[i*AB +: AB]     = pc;
    X_seq_num[i*SB +: SB] = seq;
    X_waddr[i*5 +: 5]    = wa;
    X_wdata[i*DB +: DB]  = wd;
    X_wen[i]             = we;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    X_val = '0;
    C_rdy = 1'b0;
    rst   = 1'b1;
    next_cycle();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    C_rdy = 1'b1;
    set_pipe(0, 1'b1, 32'h10, 5'd1, 5'd1, 32'h1, 1'b1);
    set_pipe(1, 1'b1, 32'h20, 5'd2, 5'd2, 32'h2, 1'b1);
    next_cycle();
    @(negedge clk);
    vectors++; if (X_rdy !== 2'b00) begin miscompares++; $display("FAIL reset_x_rdy got %b want 00", X_rdy); end
    vectors++; if (C_val !== 1'b0) begin miscompares++; $display("FAIL reset_c_val got %b want 0", C_val); end
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    next_cycle();
    rst   = 1'b0;
    X_val = '0;
    @(negedge clk);
    vectors++; if (C_val !== 1'b0) begin miscompares++; $display("FAIL idle_c_val got %b want 0", C_val); end
    next_cycle();
  endtask

  task automatic test_single();
    C_rdy = 1'b1;
    set_pipe(0, 1'b1, 32'h100, 5'd3, 5'd5, 32'h1234, 1'b1);
    @(negedge clk);
    vectors++; if (X_rdy !== 2'b01) begin miscompares++; $display("FAIL single_grant got %b want 01", X_rdy); end
    next_cycle();
    X_val = '0;
    @(negedge clk);
    vectors++; if (C_val !== 1'b1) begin miscompares++; $display("FAIL single_c_val got %b want 1", C_val); end
    vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL single_rf_wen got %b want 1", rf_wen); end
    vectors++; if (rf_waddr !== 5'd5) begin miscompares++; $display("FAIL single_rf_waddr got %0d want 5", rf_waddr); end
    vectors++; if (rf_wdata !== 32'h1234) begin miscompares++; $display("FAIL single_rf_wdata got %h want 1234", rf_wdata); end
    vectors++; if (C_seq_num !== 5'd3 || C_pc !== 32'h100) begin
      miscompares++; $display("FAIL single_completion got seq %0d pc %h want seq 3 pc 100", C_seq_num, C_pc); end
    next_cycle();
    @(negedge clk);
    vectors++; if (C_val !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", C_val); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [SB-1:0] seq [NP];
    logic [NP-1:0] want;
    do_reset();
    seq[0] = 5'd0;
    seq[1] = 5'd1;
    C_rdy  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NP; i++) set_pipe(i, 1'b1, 32'h400 + 32'(i), seq[i], 5'd9, 32'h0, 1'b1);
      @(negedge clk);
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      vectors++; if (X_rdy !== want) begin miscompares++; $display("FAIL rr_grant c%0d got %b want %b", c, X_rdy, want); end
      if (c > 0) begin
        vectors++; if (C_val !== 1'b1 || C_seq_num !== 5'(c - 1)) begin
          miscompares++; $display("FAIL rr_completion c%0d got val %b seq %0d want val 1 seq %0d", c, C_val, C_seq_num, c - 1); end
      end
      next_cycle();
      seq[c % 2] = seq[c % 2] + 5'd2;
    end
    X_val = '0;
    next_cycle();
  endtask

  task automatic test_backpressure();
    do_reset();
    C_rdy = 1'b1;
    set_pipe(0, 1'b1, 32'h500, 5'd10, 5'd3, 32'hAA, 1'b1);
    set_pipe(1, 1'b1, 32'h504, 5'd21, 5'd4, 32'hBB, 1'b1);
    @(negedge clk);
    vectors++; if (X_rdy !== 2'b01) begin miscompares++; $display("FAIL bp_first_grant got %b want 01", X_rdy); end
    next_cycle();
    set_pipe(0, 1'b1, 32'h508, 5'd12, 5'd6, 32'hCC, 1'b1);
    C_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (X_rdy !== 2'b00 || rf_wen !== 1'b0) begin
        miscompares++; $display("FAIL bp_stall c%0d got rdy %b rf_wen %b want 00 0", c, X_rdy, rf_wen); end
      vectors++; if (C_val !== 1'b1 || C_seq_num !== 5'd10) begin
        miscompares++; $display("FAIL bp_hold c%0d got val %b seq %0d want 1 10", c, C_val, C_seq_num); end
      next_cycle();
    end
    C_rdy = 1'b1;
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1 || rf_wdata !== 32'hAA) begin
      miscompares++; $display("FAIL bp_release_write got wen %b data %h want 1 aa", rf_wen, rf_wdata); end
    vectors++; if (X_rdy !== 2'b10) begin miscompares++; $display("FAIL bp_release_grant got %b want 10", X_rdy); end
    next_cycle();
    X_val = '0;
    @(negedge clk);
    vectors++; if (C_val !== 1'b1 || C_seq_num !== 5'd21) begin
      miscompares++; $display("FAIL bp_no_bubble got val %b seq %0d want 1 21", C_val, C_seq_num); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_x0_write();
    C_rdy = 1'b1;
    X_val = '0;
    set_pipe(1, 1'b1, 32'h600, 5'd9, 5'd0, 32'hFFFF, 1'b1);
    @(negedge clk);
    vectors++; if (X_rdy !== 2'b10) begin miscompares++; $display("FAIL x0_grant got %b want 10", X_rdy); end
    next_cycle();
    X_val = '0;
    @(negedge clk);
    vectors++; if (C_val !== 1'b1 || rf_wen !== 1'b0 || C_seq_num !== 5'd9) begin
      miscompares++; $display("FAIL x0_complete got val %b rf_wen %b seq %0d want 1 0 9", C_val, rf_wen, C_seq_num); end
    next_cycle();
    @(negedge clk);
    vectors++; if (C_val !== 1'b0) begin miscompares++; $display("FAIL x0_retired got %b want 0", C_val); end
    next_cycle();
  endtask

  task automatic test_wen_off();
    C_rdy = 1'b1;
    X_val = '0;
    set_pipe(0, 1'b1, 32'h200, 5'd17, 5'd7, 32'h55, 1'b0);
    @(negedge clk);
    vectors++; if (X_rdy !== 2'b01) begin miscompares++; $display("FAIL wen0_grant got %b want 01", X_rdy); end
    next_cycle();
    X_val = '0;
    @(negedge clk);
    vectors++; if (C_val !== 1'b1 || rf_wen !== 1'b0 || C_seq_num !== 5'd17 || C_pc !== 32'h200) begin
      miscompares++; $display("FAIL wen0_complete got val %b rf_wen %b seq %0d pc %h want 1 0 17 200",
                              C_val, rf_wen, C_seq_num, C_pc); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    C_rdy = 1'b1;
    X_val = '0;
    set_pipe(0, 1'b1, 32'h700, 5'd4, 5'd8, 32'h77, 1'b1);
    next_cycle();
    X_val = '0;
    C_rdy = 1'b0;
    next_cycle();
    rst   = 1'b1;
    C_rdy = 1'b1;
    @(negedge clk);
    vectors++; if (C_val !== 1'b0 || rf_wen !== 1'b0) begin
      miscompares++; $display("FAIL midrst_cycle got val %b rf_wen %b want 0 0", C_val, rf_wen); end
    next_cycle();
    rst = 1'b0;
    set_pipe(0, 1'b1, 32'h800, 5'd1, 5'd1, 32'h1, 1'b1);
    set_pipe(1, 1'b1, 32'h804, 5'd2, 5'd2, 32'h2, 1'b1);
    @(negedge clk);
    vectors++; if (C_val !== 1'b0) begin miscompares++; $display("FAIL midrst_dropped got %b want 0", C_val); end
    vectors++; if (X_rdy !== 2'b01) begin miscompares++; $display("FAIL midrst_ptr got %b want 01", X_rdy); end
    next_cycle();
    X_val = '0;
    next_cycle();
  endtask

  task automatic test_random();
    logic          pv  [NP];
    logic [AB-1:0] ppc [NP];
    logic [SB-1:0] pseq[NP];
    logic [4:0]    pwa [NP];
    logic [DB-1:0] pwd [NP];
    logic          pwe [NP];
    logic          m_val;
    logic [AB-1:0] m_pc;
    logic [SB-1:0] m_seq;
    logic [4:0]    m_wa;
    logic [DB-1:0] m_wd;
    logic          m_we;
    int            m_ptr;
    int            g;
    logic [NP-1:0] want_rdy;
    logic          want_rfw;
    do_reset();
    m_val = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < NP; i++) pv[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        // A pipe keeps an unaccepted request unchanged; otherwise it may present a fresh one.
        if (!pv[i]) begin
          pv[i]   = ($urandom_range(0, 2) != 0);
          ppc[i]  = $urandom;
          pseq[i] = 5'($urandom);
          pwa[i]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
          pwd[i]  = $urandom;
          pwe[i]  = ($urandom_range(0, 3) != 0);
        end
        set_pipe(i, pv[i], ppc[i], pseq[i], pwa[i], pwd[i], pwe[i]);
      end
      C_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = -1;
      if (!m_val || C_rdy)
        for (int k = 0; k < NP; k++)
          if (g < 0 && pv[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
      want_rdy = (g >= 0) ? (NP'(1) << g) : '0;
      want_rfw = m_val && C_rdy && m_we && (m_wa != 5'd0);
      vectors++; if (X_rdy !== want_rdy) begin
        miscompares++; $display("FAIL rand_rdy c%0d got %b want %b", c, X_rdy, want_rdy); end
      vectors++; if (C_val !== m_val || rf_wen !== want_rfw) begin
        miscompares++; $display("FAIL rand_ctrl c%0d got val %b rf_wen %b want %b %b", c, C_val, rf_wen, m_val, want_rfw); end
      if (m_val) begin
        vectors++; if (C_seq_num !== m_seq || C_pc !== m_pc) begin
          miscompares++; $display("FAIL rand_completion c%0d got seq %0d pc %h want %0d %h", c, C_seq_num, C_pc, m_seq, m_pc); end
      end
      if (want_rfw) begin
        vectors++; if (rf_waddr !== m_wa || rf_wdata !== m_wd) begin
          miscompares++; $display("FAIL rand_rf c%0d got addr %0d data %h want %0d %h", c, rf_waddr, rf_wdata, m_wa, m_wd); end
      end
`ifdef WRITEBACK_ARBITER_BYPASS_EN
      vectors++; if (byp_val !== (m_val && m_we && (m_wa != 5'd0))) begin
        miscompares++; $display("FAIL rand_byp c%0d got %b", c, byp_val); end
`endif
      next_cycle();
      if (g >= 0) begin
        m_val = 1'b1;
        m_pc  = ppc[g];
        m_seq = pseq[g];
        m_wa  = pwa[g];
        m_wd  = pwd[g];
        m_we  = pwe[g];
        pv[g] = 1'b0;
        m_ptr = (g + 1) % NP;
      end else if (m_val && C_rdy) begin
        m_val = 1'b0;
      end
    end
    X_val = '0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_x0_write();
    test_wen_off();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
